multi_ready_detector: RTL and testbench

Multi-channel, parametrised readiness detector for slow "ready-style" status inputs such as configuration-clock and done lines. Each channel asserts its `ready` output only after its input has been high for `ASSERT_CYCLES` consecutive clocks. Unlike the single-channel legacy detector, a channel drops `ready` only after `DEASSERT_CYCLES` consecutive low samples, so short low glitches are filtered out. The block also reports rise/fall events, sticky loss flags and saturating drop counters. It sits at the top of the design and gates start-up of downstream logic, typically via `all_ready`.

---
 rtl/multi_ready_detector.sv | 162 ++++++++++++++++
 tb/tb_multi_ready_detector.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ready_detector.sv
// Per-channel readiness detector with assert qualification, deassert glitch filter,
// rise/fall events, sticky loss flags and saturating drop counters. Optional macro: MULTI_READY_SYNC_EN.
module multi_ready_detector #(
    parameter int CHANNELS        = 4,
    parameter int ASSERT_CYCLES   = 2000,
    parameter int DEASSERT_CYCLES = 1,
    localparam int MAXC = (ASSERT_CYCLES > DEASSERT_CYCLES) ? ASSERT_CYCLES : DEASSERT_CYCLES,
    localparam int CW   = $clog2(MAXC + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CHANNELS-1:0]     sig_in,
    input  logic [CHANNELS-1:0]     lost_clr,
    output logic [CHANNELS-1:0]     ready,
    output logic                    all_ready,
    output logic [CHANNELS-1:0]     rise_pulse,
    output logic [CHANNELS-1:0]     fall_pulse,
    output logic [CHANNELS-1:0]     lost,
    output logic [8*CHANNELS-1:0]   drop_cnt
);

    typedef enum logic [1:0] {IDLE, RDY, HOLD} state_t;

    localparam logic [CW-1:0] A_LAST = CW'(ASSERT_CYCLES - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DEASSERT_CYCLES - 1);

    logic [CHANNELS-1:0] s_in;
    logic [CHANNELS-1:0] ready_next;
    logic                all_ready_reg;

`ifdef MULTI_READY_SYNC_EN
    logic [CHANNELS-1:0] sync1_reg;
    logic [CHANNELS-1:0] sync2_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= sig_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign s_in = sync2_reg;
`else
    assign s_in = sig_in;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            state_t          state_reg;
            logic [CW-1:0]   ctr_reg;
            logic            ready_reg;
            logic            rise_reg;
            logic            fall_reg;
            logic            lost_reg;
            logic [7:0]      cnt_reg;
            logic            s;
            logic            rdy_next;
            logic            fall_evt;

            assign s = s_in[gi];

            // Ready after this edge, derived from the transition rules; also feeds all_ready.
            always_comb begin
                rdy_next = 1'b0;
                case (state_reg)
                    IDLE:    rdy_next = s && (ctr_reg == A_LAST);
                    RDY:     rdy_next = s || (DEASSERT_CYCLES > 1);
                    HOLD:    rdy_next = s || (ctr_reg != D_LAST);
                    default: rdy_next = 1'b0;
                endcase
            end

            assign fall_evt = (state_reg != IDLE) && !rdy_next;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= IDLE;
                    ctr_reg   <= '0;
                    ready_reg <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                    lost_reg  <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    rise_reg <= 1'b0;
                    fall_reg <= fall_evt;
                    case (state_reg)
                        IDLE: begin
                            if (!s) begin
                                ctr_reg <= '0;
                            end else if (ctr_reg == A_LAST) begin
                                state_reg <= RDY;
                                ctr_reg   <= '0;
                                rise_reg  <= 1'b1;
                            end else begin
                                ctr_reg <= ctr_reg + 1'b1;
                            end
                        end
                        RDY: begin
                            if (s) begin
                                ctr_reg <= '0;
                            end else if (DEASSERT_CYCLES == 1) begin
                                state_reg <= IDLE;
                                ctr_reg   <= '0;
                            end else begin
                                state_reg <= HOLD;
                                ctr_reg   <= CW'(1);
                            end
                        end
                        HOLD: begin
                            if (s) begin
                                state_reg <= RDY;
                                ctr_reg   <= '0;
                            end else if (ctr_reg == D_LAST) begin
                                state_reg <= IDLE;
                                ctr_reg   <= '0;
                            end else begin
                                ctr_reg <= ctr_reg + 1'b1;
                            end
                        end
                        default: begin
                            state_reg <= IDLE;
                            ctr_reg   <= '0;
                        end
                    endcase
                    ready_reg <= rdy_next;
                    // A fall coinciding with a clear keeps the flag set.
                    if (fall_evt) begin
                        lost_reg <= 1'b1;
                    end else if (lost_clr[gi]) begin
                        lost_reg <= 1'b0;
                    end
                    if (fall_evt && (cnt_reg != 8'hFF)) begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
            end

            assign ready_next[gi]       = rdy_next;
            assign ready[gi]            = ready_reg;
            assign rise_pulse[gi]       = rise_reg;
            assign fall_pulse[gi]       = fall_reg;
            assign lost[gi]             = lost_reg;
            assign drop_cnt[8*gi +: 8]  = cnt_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            all_ready_reg <= 1'b0;
        end else begin
            all_ready_reg <= &ready_next;
        end
    end

    assign all_ready = all_ready_reg;

endmodule

// File: tb/tb_multi_ready_detector.sv
// Self-checking bench for multi_ready_detector: directed scenarios plus randomized traffic,
// all compared against a run-length reference model of the readiness rules.
module tb_multi_ready_detector;

    localparam int CH = 2;
    localparam int A  = 4;
    localparam int D  = 3;
`ifdef MULTI_READY_SYNC_EN
    localparam int LAT = A + 2;
`else
    localparam int LAT = A;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH-1:0]   sig_in = '0;
    logic [CH-1:0]   lost_clr = '0;
    logic [CH-1:0]   ready;
    logic            all_ready;
    logic [CH-1:0]   rise_pulse;
    logic [CH-1:0]   fall_pulse;
    logic [CH-1:0]   lost;
    logic [8*CH-1:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    multi_ready_detector #(
        .CHANNELS(CH), .ASSERT_CYCLES(A), .DEASSERT_CYCLES(D)
    ) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .lost_clr(lost_clr),
        .ready(ready), .all_ready(all_ready), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .lost(lost), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: counts consecutive high/low samples per channel.
    logic [CH-1:0] m_ready, m_rise, m_fall, m_lost;
    logic          m_all;
    int            m_hi [CH];
    int            m_lo [CH];
    int            m_cnt [CH];
    logic [CH-1:0] m_p1, m_p2;

    logic [24:0] act;
    assign act = {ready, all_ready, rise_pulse, fall_pulse, lost, drop_cnt};

    function automatic logic [24:0] exp_vec();
        return {m_ready, m_all, m_rise, m_fall, m_lost, 8'(m_cnt[1]), 8'(m_cnt[0])};
    endfunction

    task automatic model_step(input logic [CH-1:0] s, input logic [CH-1:0] c, input logic r);
        logic [CH-1:0] e;
`ifdef MULTI_READY_SYNC_EN
        e = m_p2; m_p2 = m_p1; m_p1 = s;
`else
        e = s;
`endif
        if (r) begin
            m_ready = '0; m_rise = '0; m_fall = '0; m_lost = '0; m_all = 1'b0;
            m_p1 = '0; m_p2 = '0;
            for (int i = 0; i < CH; i++) begin m_hi[i] = 0; m_lo[i] = 0; m_cnt[i] = 0; end
            return;
        end
        for (int i = 0; i < CH; i++) begin
            m_rise[i] = 1'b0; m_fall[i] = 1'b0;
            if (!m_ready[i]) begin
                if (e[i]) begin
                    m_hi[i]++;
                    if (m_hi[i] == A) begin m_ready[i] = 1'b1; m_rise[i] = 1'b1; m_hi[i] = 0; m_lo[i] = 0; end
                end else m_hi[i] = 0;
            end else begin
                if (!e[i]) begin
                    m_lo[i]++;
                    if (m_lo[i] == D) begin m_ready[i] = 1'b0; m_fall[i] = 1'b1; m_lo[i] = 0; m_hi[i] = 0; end
                end else m_lo[i] = 0;
            end
            if (m_fall[i]) m_lost[i] = 1'b1;
            else if (c[i]) m_lost[i] = 1'b0;
            if (m_fall[i] && m_cnt[i] < 255) m_cnt[i]++;
        end
        m_all = &m_ready;
    endtask

    task automatic tick(input logic [CH-1:0] s, input logic [CH-1:0] c, input logic r);
        @(negedge clk);
        sig_in = s; lost_clr = c; rst = r;
        @(posedge clk);
        model_step(s, c, r);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(2'b00, 2'b00, 1'b1);
            checks++;
            if (act !== 25'd0) begin
                errors++; $display("FAIL reset_state actual=%h required=0", act);
            end
        end
        model_step(2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(2'b00, 2'b00, 1'b0);
            checks++;
            if (act !== exp_vec()) begin
                errors++; $display("FAIL idle actual=%h required=%h", act, exp_vec());
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_assert();
        for (int i = 1; i <= LAT + 2; i++) begin
            tick(2'b01, 2'b00, 1'b0);
            checks++;
            if (act !== exp_vec()) begin
                errors++; $display("FAIL assert_model cyc=%0d actual=%h required=%h", i, act, exp_vec());
            end
            checks++;
            if (ready[0] !== (i >= LAT) || rise_pulse[0] !== (i == LAT) || ready[1] !== 1'b0 || all_ready !== 1'b0) begin
                errors++;
                $display("FAIL assert_latency cyc=%0d ready=%b rise=%b all=%b required ready0=%b rise0=%b",
                         i, ready, rise_pulse, all_ready, i >= LAT, i == LAT);
            end
        end
        $display("test_assert done");
    endtask

    task automatic test_glitch();
        logic [CH-1:0] pat [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
        for (int i = 0; i < 6; i++) begin
            tick(pat[i], 2'b00, 1'b0);
            checks++;
            if (act !== exp_vec() || ready[0] !== 1'b1 || fall_pulse !== 2'b00 || drop_cnt[7:0] !== 8'd0) begin
                errors++; $display("FAIL glitch cyc=%0d actual=%h required=%h", i, act, exp_vec());
            end
        end
        $display("test_glitch done");
    endtask

    task automatic test_fall_clear();
        int falls = 0;
        for (int i = 0; i < LAT - A + D + 2; i++) begin
            tick(2'b00, 2'b00, 1'b0);
            falls += fall_pulse[0];
            checks++;
            if (act !== exp_vec()) begin
                errors++; $display("FAIL fall cyc=%0d actual=%h required=%h", i, act, exp_vec());
            end
        end
        checks++;
        if (falls != 1 || ready[0] !== 1'b0 || lost[0] !== 1'b1 || drop_cnt[7:0] !== 8'd1) begin
            errors++;
            $display("FAIL fall_result falls=%0d ready0=%b lost0=%b cnt0=%0d required 1/0/1/1",
                     falls, ready[0], lost[0], drop_cnt[7:0]);
        end
        tick(2'b00, 2'b01, 1'b0);
        checks++;
        if (lost[0] !== 1'b0 || act !== exp_vec()) begin
            errors++; $display("FAIL lost_clr lost0=%b required=0 actual=%h", lost[0], act);
        end
        $display("test_fall_clear done");
    endtask

    task automatic test_short_run();
        logic [CH-1:0] pat [12] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01,
                                   2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        for (int i = 0; i < 12; i++) begin
            tick(pat[i], 2'b00, 1'b0);
            checks++;
            if (act !== exp_vec()) begin
                errors++; $display("FAIL short_run cyc=%0d actual=%h required=%h", i, act, exp_vec());
            end
        end
        $display("test_short_run done");
    endtask

    task automatic test_fall_with_clr();
        for (int i = 0; i < LAT + 1; i++) tick(2'b01, 2'b00, 1'b0);
        for (int i = 0; i < LAT - A + D + 2; i++) begin
            tick(2'b00, 2'b01, 1'b0);
            checks++;
            if (act !== exp_vec()) begin
                errors++; $display("FAIL fall_clr cyc=%0d actual=%h required=%h", i, act, exp_vec());
            end
            if (fall_pulse[0]) begin
                checks++;
                if (lost[0] !== 1'b1) begin
                    errors++; $display("FAIL fall_clr_set lost0=%b required=1", lost[0]);
                end
            end
        end
        $display("test_fall_with_clr done");
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < A + D; i++) begin
                tick((i < A) ? 2'b01 : 2'b00, 2'b00, 1'b0);
                checks++;
                if (act !== exp_vec()) begin
                    errors++; $display("FAIL saturate n=%0d actual=%h required=%h", n, act, exp_vec());
                end
            end
        end
        for (int i = 0; i < 4; i++) tick(2'b00, 2'b00, 1'b0);
        checks++;
        if (drop_cnt[7:0] !== 8'd255) begin
            errors++; $display("FAIL saturate_cnt actual=%0d required=255", drop_cnt[7:0]);
        end
        $display("test_saturate done");
    endtask

    task automatic test_both_reset();
        for (int i = 0; i < LAT + 1; i++) tick(2'b11, 2'b00, 1'b0);
        checks++;
        if (all_ready !== 1'b1 || ready !== 2'b11 || act !== exp_vec()) begin
            errors++; $display("FAIL all_ready actual=%b ready=%b required=1/11", all_ready, ready);
        end
        tick(2'b11, 2'b00, 1'b1);
        checks++;
        if (act !== 25'd0) begin
            errors++; $display("FAIL mid_reset actual=%h required=0", act);
        end
        tick(2'b00, 2'b00, 1'b0);
        checks++;
        if (fall_pulse !== 2'b00 || act !== exp_vec()) begin
            errors++; $display("FAIL post_reset actual=%h required=%h", act, exp_vec());
        end
        $display("test_both_reset done");
    endtask

    task automatic test_random();
        logic [CH-1:0] s = '0;
        logic [CH-1:0] c;
        logic          r;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < CH; k++) if ($urandom_range(3) == 0) s[k] = ~s[k];
            c = ($urandom_range(7) == 0) ? CH'($urandom) : '0;
            r = ($urandom_range(499) == 0);
            tick(s, c, r);
            checks++;
            if (act !== exp_vec()) begin
                errors++; $display("FAIL random cyc=%0d actual=%h required=%h", i, act, exp_vec());
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_assert();
        test_glitch();
        test_fall_clear();
        test_short_run();
        test_fall_with_clr();
        test_saturate();
        test_both_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
